// File: rtl/bilinear_scale_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// bilinear_scale_cfg_ctrl
//   Configuration scheduler for the bilinear RGB scaler. Accepts destination
//   size requests, range-checks them, computes Q4.FRAC step factors with a
//   serial restoring divider, and commits size and factors together at the
//   falling edge of the scaler's output vsync. This keeps the scaler from
//   changing geometry in the middle of a frame.
//
// Ports
//   clk_out           scaler clock, rising edge
//   sys_rst           asynchronous reset, active high
//   cfg_valid/ready   request handshake (accepted on valid & ready)
//   cfg_dst_width     requested destination width
//   cfg_dst_height    requested destination height
//   post_img_vsync    scaler output frame vsync, high during the frame
//   c_dst_img_width   active destination width
//   c_dst_img_height  active destination height
//   h_scale/v_scale   active step factors, SRC*2^FRAC/dst truncated
//   cfg_pending       new config computed, waiting for frame end
//   cfg_update        one-cycle pulse while the newly committed config shows
//   cfg_err           one-cycle pulse after a rejected request
// -----------------------------------------------------------------------------
module bilinear_scale_cfg_ctrl #(
  parameter int SRC_W   = 640,
  parameter int SRC_H   = 480,
  parameter int DEF_W   = 640,
  parameter int DEF_H   = 480,
  parameter int MIN_DST = 64,
  parameter int MAX_W   = 2560,
  parameter int MAX_H   = 1440,
  parameter int FRAC    = 16,
  parameter int QW      = FRAC + 4
) (
  input  logic          clk_out,
  input  logic          sys_rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [11:0]   cfg_dst_width,
  input  logic [11:0]   cfg_dst_height,
  input  logic          post_img_vsync,
  output logic [11:0]   c_dst_img_width,
  output logic [11:0]   c_dst_img_height,
  output logic [QW-1:0] h_scale,
  output logic [QW-1:0] v_scale,
  output logic          cfg_pending,
  output logic          cfg_update,
  output logic          cfg_err
);

  localparam int DW = FRAC + 12;          // dividend width (12-bit source dim)
  localparam int RW = 13;                 // remainder width
  localparam int CW = $clog2(QW);         // quotient bit counter
  localparam int IW = $clog2(DW);         // dividend bit index

  localparam logic [DW-1:0] DIVIDEND_H = DW'(SRC_W) << FRAC;
  localparam logic [DW-1:0] DIVIDEND_V = DW'(SRC_H) << FRAC;

  localparam logic [11:0]   DEF_W_L = 12'(DEF_W);
  localparam logic [11:0]   DEF_H_L = 12'(DEF_H);
  localparam logic [QW-1:0] DEF_HS  = QW'((SRC_W * (1 << FRAC)) / DEF_W);
  localparam logic [QW-1:0] DEF_VS  = QW'((SRC_H * (1 << FRAC)) / DEF_H);

  localparam logic [11:0]   MIN_L  = 12'(MIN_DST);
  localparam logic [11:0]   MAXW_L = 12'(MAX_W);
  localparam logic [11:0]   MAXH_L = 12'(MAX_H);

  // The quotient fits in QW bits because MIN_DST bounds it below 16, so the
  // bits of the dividend above QW can never produce a quotient bit and are
  // preloaded straight into the remainder.
  localparam logic [RW-1:0] REM_INIT_H = {{(RW-(DW-QW)){1'b0}}, DIVIDEND_H[DW-1:QW]};
  localparam logic [RW-1:0] REM_INIT_V = {{(RW-(DW-QW)){1'b0}}, DIVIDEND_V[DW-1:QW]};

  typedef enum logic [2:0] {S_IDLE, S_DIV_H, S_DIV_V, S_PEND, S_APPLY} state_t;

  state_t          state, state_nxt;
  logic            vsync_d;
  logic            vsync_fall;
  logic            req_legal;
  logic [11:0]     sh_w, sh_h;
  logic [QW-1:0]   sh_hs, sh_vs;
  logic [RW-1:0]   rem, rem_nxt;
  logic [QW-1:0]   quo, quo_nxt;
  logic [CW-1:0]   cnt;
  logic            div_last;
  logic [11:0]     divisor;
  logic [IW-1:0]   bit_idx;
  logic            dvd_bit;
  logic [RW:0]     trial, diff;
  logic            trial_ge;

  assign vsync_fall = vsync_d & ~post_img_vsync;
  assign req_legal  = (cfg_dst_width  >= MIN_L) && (cfg_dst_width  <= MAXW_L) &&
                      (cfg_dst_height >= MIN_L) && (cfg_dst_height <= MAXH_L);
  assign div_last   = (cnt == CW'(QW - 1));

  // One restoring-division step: shift the next dividend bit (MSB first)
  // into the remainder and subtract the divisor if it fits.
  always_comb begin
    divisor  = (state == S_DIV_V) ? sh_h : sh_w;
    bit_idx  = IW'(QW - 1) - IW'(cnt);
    dvd_bit  = (state == S_DIV_V) ? DIVIDEND_V[bit_idx] : DIVIDEND_H[bit_idx];
    trial    = {rem, dvd_bit};
    diff     = trial - {2'b00, divisor};
    trial_ge = (trial >= {2'b00, divisor});
    rem_nxt  = trial_ge ? RW'(diff) : RW'(trial);
    quo_nxt  = {quo[QW-2:0], trial_ge};
  end

  always_ff @(posedge clk_out or posedge sys_rst) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cfg_valid && req_legal) state_nxt = S_DIV_H;
      S_DIV_H: if (div_last)               state_nxt = S_DIV_V;
      S_DIV_V: if (div_last)               state_nxt = S_PEND;
      S_PEND:  if (vsync_fall)             state_nxt = S_APPLY;
      S_APPLY:                             state_nxt = S_IDLE;
      default:                             state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_out or posedge sys_rst) begin
    if (sys_rst) begin
      cfg_ready        <= 1'b1;
      cfg_pending      <= 1'b0;
      cfg_update       <= 1'b0;
      cfg_err          <= 1'b0;
      vsync_d          <= 1'b0;
      c_dst_img_width  <= DEF_W_L;
      c_dst_img_height <= DEF_H_L;
      h_scale          <= DEF_HS;
      v_scale          <= DEF_VS;
      sh_w             <= DEF_W_L;
      sh_h             <= DEF_H_L;
      sh_hs            <= DEF_HS;
      sh_vs            <= DEF_VS;
      rem              <= '0;
      quo              <= '0;
      cnt              <= '0;
    end else begin
      cfg_err    <= 1'b0;
      cfg_update <= 1'b0;
      vsync_d    <= post_img_vsync;
      cfg_ready  <= (state_nxt == S_IDLE);

      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            if (req_legal) begin
              sh_w <= cfg_dst_width;
              sh_h <= cfg_dst_height;
              rem  <= REM_INIT_H;
              quo  <= '0;
              cnt  <= '0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_DIV_H: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
          if (div_last) begin
            sh_hs <= quo_nxt;
            rem   <= REM_INIT_V;
            quo   <= '0;
            cnt   <= '0;
          end
        end
        S_DIV_V: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
          if (div_last) begin
            sh_vs       <= quo_nxt;
            cfg_pending <= 1'b1;
          end
        end
        S_PEND: begin
          // Commit on the edge into APPLY so the new values and the
          // cfg_update pulse are visible together during APPLY.
          if (vsync_fall) begin
            c_dst_img_width  <= sh_w;
            c_dst_img_height <= sh_h;
            h_scale          <= sh_hs;
            v_scale          <= sh_vs;
            cfg_update       <= 1'b1;
            cfg_pending      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bilinear_scale_cfg_ctrl.sv
module tb_bilinear_scale_cfg_ctrl;

  logic        clk_out = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [11:0] cfg_dst_width = 12'd0;
  logic [11:0] cfg_dst_height = 12'd0;
  logic        post_img_vsync = 1'b0;
  logic [11:0] c_dst_img_width;
  logic [11:0] c_dst_img_height;
  logic [19:0] h_scale;
  logic [19:0] v_scale;
  logic        cfg_pending;
  logic        cfg_update;
  logic        cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  bilinear_scale_cfg_ctrl dut (
    .clk_out          (clk_out),
    .sys_rst          (sys_rst),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_dst_width    (cfg_dst_width),
    .cfg_dst_height   (cfg_dst_height),
    .post_img_vsync   (post_img_vsync),
    .c_dst_img_width  (c_dst_img_width),
    .c_dst_img_height (c_dst_img_height),
    .h_scale          (h_scale),
    .v_scale          (v_scale),
    .cfg_pending      (cfg_pending),
    .cfg_update       (cfg_update),
    .cfg_err          (cfg_err)
  );

  always #5 clk_out = ~clk_out;

  // Present a request for one cycle; returns in cycle T+1.
  task automatic send_req(input logic [11:0] w, input logic [11:0] h);
    @(negedge clk_out);
    cfg_valid = 1'b1; cfg_dst_width = w; cfg_dst_height = h;
    @(negedge clk_out);
    cfg_valid = 1'b0;
  endtask

  // Raise vsync for a few cycles then drop it; returns in the fall cycle.
  task automatic vsync_frame();
    @(negedge clk_out); post_img_vsync = 1'b1;
    repeat (3) @(negedge clk_out);
    post_img_vsync = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (c_dst_img_width !== 12'd640) begin n_fail++; $display("FAIL reset_w got %0d want 640", c_dst_img_width); end
    n_checks++; if (c_dst_img_height !== 12'd480) begin n_fail++; $display("FAIL reset_h got %0d want 480", c_dst_img_height); end
    n_checks++; if (h_scale !== 20'h10000) begin n_fail++; $display("FAIL reset_hs got %h want 10000", h_scale); end
    n_checks++; if (v_scale !== 20'h10000) begin n_fail++; $display("FAIL reset_vs got %h want 10000", v_scale); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", cfg_ready); end
    n_checks++; if ({cfg_pending, cfg_update, cfg_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {cfg_pending, cfg_update, cfg_err}); end
  endtask

  task automatic test_commit();
    send_req(12'd1920, 12'd1080);                     // now cycle T+1
    n_checks++; if ({cfg_ready, cfg_err} !== 2'b00) begin n_fail++; $display("FAIL commit_accept ready/err got %b want 00", {cfg_ready, cfg_err}); end
    repeat (39) @(negedge clk_out);                   // cycle T+40
    n_checks++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL commit_pend_early got %b want 0", cfg_pending); end
    @(negedge clk_out);                               // cycle T+41
    n_checks++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL commit_pend_t41 got %b want 1", cfg_pending); end
    n_checks++; if (c_dst_img_width !== 12'd640 || h_scale !== 20'h10000) begin n_fail++; $display("FAIL commit_shadow_hidden got %0d/%h want 640/10000", c_dst_img_width, h_scale); end
    vsync_frame();
    @(negedge clk_out);
    n_checks++; if (cfg_update !== 1'b1) begin n_fail++; $display("FAIL commit_update got %b want 1", cfg_update); end
    n_checks++; if (c_dst_img_width !== 12'd1920 || c_dst_img_height !== 12'd1080) begin n_fail++; $display("FAIL commit_wh got %0d/%0d want 1920/1080", c_dst_img_width, c_dst_img_height); end
    n_checks++; if (h_scale !== 20'h05555) begin n_fail++; $display("FAIL commit_hs got %h want 05555", h_scale); end
    n_checks++; if (v_scale !== 20'h071C7) begin n_fail++; $display("FAIL commit_vs got %h want 071c7", v_scale); end
    n_checks++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL commit_pend_clear got %b want 0", cfg_pending); end
    @(negedge clk_out);
    n_checks++; if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL commit_update_pulse got %b want 0", cfg_update); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL commit_ready_back got %b want 1", cfg_ready); end
  endtask

  task automatic test_fall_during_div();
    int upd_seen = 0;
    send_req(12'd1280, 12'd600);                      // cycle T+1
    repeat (4) @(negedge clk_out);
    vsync_frame();                                    // fall near T+9..T+10
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_out);
      if (cfg_update) upd_seen++;
    end
    n_checks++; if (upd_seen !== 0) begin n_fail++; $display("FAIL div_fall_update got %0d pulses want 0", upd_seen); end
    n_checks++; if (c_dst_img_width !== 12'd1920 || v_scale !== 20'h071C7) begin n_fail++; $display("FAIL div_fall_unchanged got %0d/%h want 1920/071c7", c_dst_img_width, v_scale); end
    n_checks++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL div_fall_pending got %b want 1", cfg_pending); end
    vsync_frame();
    @(negedge clk_out);
    n_checks++; if (cfg_update !== 1'b1) begin n_fail++; $display("FAIL div_fall_commit got %b want 1", cfg_update); end
    n_checks++; if (c_dst_img_width !== 12'd1280 || c_dst_img_height !== 12'd600) begin n_fail++; $display("FAIL div_fall_wh got %0d/%0d want 1280/600", c_dst_img_width, c_dst_img_height); end
    n_checks++; if (h_scale !== 20'h08000 || v_scale !== 20'h0CCCC) begin n_fail++; $display("FAIL div_fall_scales got %h/%h want 08000/0cccc", h_scale, v_scale); end
    repeat (2) @(negedge clk_out);
  endtask

  task automatic test_illegal();
    logic [11:0] bad_w [3] = '{12'd30, 12'd2600, 12'd63};
    logic [11:0] bad_h [3] = '{12'd480, 12'd480, 12'd1441};
    for (int i = 0; i < 3; i++) begin
      send_req(bad_w[i], bad_h[i]);
      n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL illegal_err[%0d] got %b want 1", i, cfg_err); end
      n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready[%0d] got %b want 1", i, cfg_ready); end
      @(negedge clk_out);
      n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_pulse[%0d] got %b want 0", i, cfg_err); end
      n_checks++; if (c_dst_img_width !== 12'd1280 || h_scale !== 20'h08000 || cfg_pending !== 1'b0) begin n_fail++; $display("FAIL illegal_unchanged[%0d] got %0d/%h/%b want 1280/08000/0", i, c_dst_img_width, h_scale, cfg_pending); end
    end
  endtask

  // Max legal size accepted while cfg_valid stays high with a different
  // size through DIV and PEND; only the first request may commit.
  task automatic test_held_valid();
    int err_seen = 0;
    @(negedge clk_out);
    cfg_valid = 1'b1; cfg_dst_width = 12'd2560; cfg_dst_height = 12'd1440;
    @(negedge clk_out);
    cfg_dst_width = 12'd64; cfg_dst_height = 12'd64;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk_out);
      if (cfg_err) err_seen++;
    end
    n_checks++; if (err_seen !== 0 || cfg_ready !== 1'b0) begin n_fail++; $display("FAIL held_ignored err=%0d ready=%b want 0/0", err_seen, cfg_ready); end
    cfg_valid = 1'b0;
    vsync_frame();
    @(negedge clk_out);
    n_checks++; if (c_dst_img_width !== 12'd2560 || c_dst_img_height !== 12'd1440) begin n_fail++; $display("FAIL held_wh got %0d/%0d want 2560/1440", c_dst_img_width, c_dst_img_height); end
    n_checks++; if (h_scale !== 20'h04000 || v_scale !== 20'h05555) begin n_fail++; $display("FAIL held_scales got %h/%h want 04000/05555", h_scale, v_scale); end
    repeat (2) @(negedge clk_out);
  endtask

  task automatic test_min_boundary();
    send_req(12'd64, 12'd64);
    n_checks++; if (cfg_err !== 1'b0 || cfg_ready !== 1'b0) begin n_fail++; $display("FAIL min_accept err/ready got %b%b want 00", cfg_err, cfg_ready); end
    repeat (41) @(negedge clk_out);
    vsync_frame();
    @(negedge clk_out);
    n_checks++; if (h_scale !== 20'hA0000 || v_scale !== 20'h78000) begin n_fail++; $display("FAIL min_scales got %h/%h want a0000/78000", h_scale, v_scale); end
    n_checks++; if (c_dst_img_width !== 12'd64 || c_dst_img_height !== 12'd64) begin n_fail++; $display("FAIL min_wh got %0d/%0d want 64/64", c_dst_img_width, c_dst_img_height); end
    repeat (2) @(negedge clk_out);
  endtask

  task automatic test_reset_mid();
    int upd_seen = 0;
    send_req(12'd1920, 12'd1080);
    repeat (25) @(negedge clk_out);                   // inside DIV_V
    #2 sys_rst = 1'b1;
    #1;
    n_checks++; if (c_dst_img_width !== 12'd640 || c_dst_img_height !== 12'd480) begin n_fail++; $display("FAIL rstmid_wh got %0d/%0d want 640/480", c_dst_img_width, c_dst_img_height); end
    n_checks++; if (h_scale !== 20'h10000 || v_scale !== 20'h10000) begin n_fail++; $display("FAIL rstmid_scales got %h/%h want 10000/10000", h_scale, v_scale); end
    @(negedge clk_out);
    sys_rst = 1'b0;
    repeat (2) @(negedge clk_out);
    n_checks++; if (cfg_ready !== 1'b1 || cfg_pending !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready got %b/%b want 1/0", cfg_ready, cfg_pending); end
    vsync_frame();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_out);
      if (cfg_update) upd_seen++;
    end
    n_checks++; if (upd_seen !== 0 || c_dst_img_width !== 12'd640) begin n_fail++; $display("FAIL rstmid_discard got upd=%0d w=%0d want 0/640", upd_seen, c_dst_img_width); end
  endtask

  initial begin
    repeat (3) @(negedge clk_out);
    sys_rst = 1'b0;
    repeat (2) @(negedge clk_out);
    test_reset();
    test_commit();
    test_fall_during_div();
    test_illegal();
    test_held_valid();
    test_min_boundary();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
